// File: rtl/gamma_lut_mc_if.sv
// Pixel stream, table-load and corrected-output signals of gamma_lut_mc.
// The bypass field exists only when GAMMA_LUT_BYPASS_EN is defined.
interface gamma_lut_mc_if #(
    parameter int unsigned CH = 2,
    parameter int unsigned DW = 8,
    parameter int unsigned OW = 8
) ();
    localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH*DW-1:0] raw_data;
    logic             raw_data_valid;
    logic             raw_data_sop;
    logic             raw_data_eop;
`ifdef GAMMA_LUT_BYPASS_EN
    logic             bypass;
`endif
    logic             tbl_wr_en;
    logic [CW-1:0]    tbl_wr_ch;
    logic [DW-1:0]    tbl_wr_addr;
    logic [OW-1:0]    tbl_wr_data;
    logic             tbl_swap_req;
    logic             tbl_swap_pending;
    logic             tbl_active_bank;
    logic [CH*OW-1:0] gamma_data;
    logic             gamma_data_valid;
    logic             gamma_data_sop;
    logic             gamma_data_eop;

    modport master (
        output raw_data, raw_data_valid, raw_data_sop, raw_data_eop,
`ifdef GAMMA_LUT_BYPASS_EN
        output bypass,
`endif
        output tbl_wr_en, tbl_wr_ch, tbl_wr_addr, tbl_wr_data, tbl_swap_req,
        input  tbl_swap_pending, tbl_active_bank,
        input  gamma_data, gamma_data_valid, gamma_data_sop, gamma_data_eop
    );

    modport slave (
        input  raw_data, raw_data_valid, raw_data_sop, raw_data_eop,
`ifdef GAMMA_LUT_BYPASS_EN
        input  bypass,
`endif
        input  tbl_wr_en, tbl_wr_ch, tbl_wr_addr, tbl_wr_data, tbl_swap_req,
        output tbl_swap_pending, tbl_active_bank,
        output gamma_data, gamma_data_valid, gamma_data_sop, gamma_data_eop
    );
endinterface

// File: rtl/gamma_lut_mc.sv
// Multi-channel gamma LUT with double-buffered tables swapped only at frame start.
// Optional GAMMA_LUT_BYPASS_EN adds a per-sample bypass of the LUT.
module gamma_lut_mc #(
    parameter int unsigned CH = 2,
    parameter int unsigned DW = 8,
    parameter int unsigned OW = 8
) (
    input logic           clk,
    input logic           reset,
    gamma_lut_mc_if.slave bus
);
    localparam int unsigned CW    = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned DEPTH = 1 << DW;

    logic             active_bank;
    logic             swap_pending;
    logic             apply_c;
    logic             lookup_bank_c;

    logic [CH*DW-1:0] addr_s1;
    logic             bank_s1;
    logic             vld_s1;
    logic             sop_s1;
    logic             eop_s1;
    logic             byp_s1;

    logic [OW-1:0]    word_c [CH];
    logic [CH*OW-1:0] gamma_q;
    logic             vld_s2;
    logic             sop_s2;
    logic             eop_s2;

    // A swap applies only on a valid SOP; that SOP pixel already uses the new bank.
    assign apply_c       = bus.raw_data_valid & bus.raw_data_sop & swap_pending;
    assign lookup_bank_c = active_bank ^ apply_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_bank  <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            if (apply_c) begin
                active_bank <= ~active_bank;
            end
            swap_pending <= bus.tbl_swap_req | (swap_pending & ~apply_c);
        end
    end

    // Stage 1: address, bank select and strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_s1 <= '0;
            bank_s1 <= 1'b0;
            vld_s1  <= 1'b0;
            sop_s1  <= 1'b0;
            eop_s1  <= 1'b0;
            byp_s1  <= 1'b0;
        end else begin
            addr_s1 <= bus.raw_data;
            bank_s1 <= lookup_bank_c;
            vld_s1  <= bus.raw_data_valid;
            sop_s1  <= bus.raw_data_sop;
            eop_s1  <= bus.raw_data_eop;
`ifdef GAMMA_LUT_BYPASS_EN
            byp_s1  <= bus.bypass;
`else
            byp_s1  <= 1'b0;
`endif
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [OW-1:0] mem [2][DEPTH];
        logic [DW-1:0] rd_addr_c;
        logic [OW-1:0] lut_c;
        logic [OW-1:0] byp_c;

        assign rd_addr_c = addr_s1[c*DW +: DW];
        assign lut_c     = mem[bank_s1][rd_addr_c];

        // Writes land in the bank that is shadow at write time; contents survive reset.
        always_ff @(posedge clk) begin
            if (bus.tbl_wr_en && (bus.tbl_wr_ch == CW'(c))) begin
                mem[~active_bank][bus.tbl_wr_addr] <= bus.tbl_wr_data;
            end
        end

        if (OW >= DW) begin : g_ext
            assign byp_c = OW'(rd_addr_c);
        end else begin : g_msb
            assign byp_c = rd_addr_c[DW-1 -: OW];
        end

        assign word_c[c] = byp_s1 ? byp_c : lut_c;
    end

    // Stage 2: data only updates on valid samples so it holds across gaps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gamma_q <= '0;
            vld_s2  <= 1'b0;
            sop_s2  <= 1'b0;
            eop_s2  <= 1'b0;
        end else begin
            if (vld_s1) begin
                for (int i = 0; i < CH; i++) begin
                    gamma_q[i*OW +: OW] <= word_c[i];
                end
            end
            vld_s2 <= vld_s1;
            sop_s2 <= vld_s1 & sop_s1;
            eop_s2 <= vld_s1 & eop_s1;
        end
    end

    assign bus.gamma_data       = gamma_q;
    assign bus.gamma_data_valid = vld_s2;
    assign bus.gamma_data_sop   = sop_s2;
    assign bus.gamma_data_eop   = eop_s2;
    assign bus.tbl_active_bank  = active_bank;
    assign bus.tbl_swap_pending = swap_pending;
endmodule

// File: tb/tb_gamma_lut_mc.sv
// Scoreboard bench for gamma_lut_mc (CH=2, DW=OW=8); bypass vector when GAMMA_LUT_BYPASS_EN is defined.
module tb_gamma_lut_mc;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        int          due;
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] last_data = '0;

    gamma_lut_mc_if #(.CH(2), .DW(8), .OW(8)) bus ();
    gamma_lut_mc #(.CH(2), .DW(8), .OW(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per output beat; checks timing, and data hold in gaps.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            last_data = '0;
        end else if (bus.gamma_data_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(bus.gamma_data_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data", 32'(bus.gamma_data), 32'(e.data));
                check("sop", 32'(bus.gamma_data_sop), 32'(e.sop));
                check("eop", 32'(bus.gamma_data_eop), 32'(e.eop));
                check("latency", 32'(cyc), 32'(e.due));
                last_data = e.data;
            end
        end else begin
            check("hold", 32'(bus.gamma_data), 32'(last_data));
            check("idle_strobes", 32'({bus.gamma_data_sop, bus.gamma_data_eop}), 32'd0);
            if (sb.size() != 0 && sb[0].due < cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("missing_output", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.raw_data_valid = 1'b0;
        bus.raw_data_sop   = 1'b0;
        bus.raw_data_eop   = 1'b0;
        bus.tbl_swap_req   = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_req();
        bus.raw_data_valid = 1'b0;
        bus.raw_data_sop   = 1'b0;
        bus.raw_data_eop   = 1'b0;
        bus.tbl_swap_req   = 1'b1;
        step();
        bus.tbl_swap_req   = 1'b0;
    endtask

    // exp is {ch1, ch0}, hand-computed from the table pattern of the active bank.
    task automatic pix(input logic [7:0] d0, input logic [7:0] d1, input logic s, input logic e,
                       input logic req, input logic [15:0] exp);
        exp_t x;
        bus.raw_data       = {d1, d0};
        bus.raw_data_valid = 1'b1;
        bus.raw_data_sop   = s;
        bus.raw_data_eop   = e;
        bus.tbl_swap_req   = req;
        x.due  = cyc + 2;
        x.data = exp;
        x.sop  = s;
        x.eop  = e;
        sb.push_back(x);
        step();
    endtask

    // mode 0: ch0 a->a, ch1 a->255-a.  mode 1: ch0 nibble swap, ch1 a->a+1.
    task automatic load(input int mode);
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            bus.tbl_wr_en   = 1'b1;
            bus.tbl_wr_ch   = 1'b0;
            bus.tbl_wr_addr = a;
            bus.tbl_wr_data = (mode == 0) ? a : {a[3:0], a[7:4]};
            step();
            bus.tbl_wr_ch   = 1'b1;
            bus.tbl_wr_data = (mode == 0) ? 8'(8'hFF - a) : 8'(a + 8'd1);
            step();
        end
        bus.tbl_wr_en = 1'b0;
    endtask

    task automatic check_bank(input string name, input logic bank, input logic pend);
        check({name, "_bank"}, 32'(bus.tbl_active_bank), 32'(bank));
        check({name, "_pending"}, 32'(bus.tbl_swap_pending), 32'(pend));
    endtask

    initial begin
        bus.raw_data       = '0;
        bus.raw_data_valid = 1'b0;
        bus.raw_data_sop   = 1'b0;
        bus.raw_data_eop   = 1'b0;
        bus.tbl_wr_en      = 1'b0;
        bus.tbl_wr_ch      = 1'b0;
        bus.tbl_wr_addr    = '0;
        bus.tbl_wr_data    = '0;
        bus.tbl_swap_req   = 1'b0;
`ifdef GAMMA_LUT_BYPASS_EN
        bus.bypass         = 1'b0;
`endif
        #12;
        check("rst_data", 32'(bus.gamma_data), 32'd0);
        check("rst_strobes", 32'({bus.gamma_data_valid, bus.gamma_data_sop, bus.gamma_data_eop}), 32'd0);
        check_bank("rst", 1'b0, 1'b0);
        step();
        reset = 1'b0;
        idle(2);

        // Identity load into bank 1, then swap at the first SOP.
        load(0);
        pulse_req();
        check_bank("armed", 1'b0, 1'b1);
        pix(8'h10, 8'h10, 1'b1, 1'b0, 1'b0, 16'hEF10);
        check_bank("identity", 1'b1, 1'b0);
        pix(8'h20, 8'h80, 1'b0, 1'b0, 1'b0, 16'h7F20);
        pix(8'h30, 8'hFF, 1'b0, 1'b1, 1'b0, 16'h0030);
        idle(3);

        // Bank 0 is now shadow.
        load(1);

        // Mid-frame request waits for the next SOP.
        pix(8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 16'hFD01);
        pix(8'h03, 8'h04, 1'b0, 1'b0, 1'b1, 16'hFB03);
        check_bank("midframe", 1'b1, 1'b1);
        pix(8'h05, 8'h06, 1'b0, 1'b1, 1'b0, 16'hF905);
        idle(2);
        check_bank("between_frames", 1'b1, 1'b1);
        pix(8'h12, 8'h34, 1'b1, 1'b0, 1'b0, 16'h3521);
        check_bank("next_sop", 1'b0, 1'b0);
        pix(8'h56, 8'h78, 1'b0, 1'b1, 1'b0, 16'h7965);
        idle(2);

        // Four-pixel frame with gaps.
        pix(8'h9A, 8'h00, 1'b1, 1'b0, 1'b0, 16'h01A9);
        idle(1);
        pix(8'h0F, 8'h10, 1'b0, 1'b0, 1'b0, 16'h11F0);
        idle(2);
        pix(8'hF0, 8'hFE, 1'b0, 1'b0, 1'b0, 16'hFF0F);
        idle(1);
        pix(8'h44, 8'hFF, 1'b0, 1'b1, 1'b0, 16'h0044);
        idle(3);

        // Two requests before one SOP give a single toggle.
        pulse_req();
        idle(1);
        pulse_req();
        check_bank("double_req", 1'b0, 1'b1);
        pix(8'h10, 8'h10, 1'b1, 1'b0, 1'b0, 16'hEF10);
        check_bank("one_toggle", 1'b1, 1'b0);
        pix(8'h20, 8'h20, 1'b0, 1'b1, 1'b0, 16'hDF20);
        idle(1);
        pulse_req();
        pix(8'h30, 8'h30, 1'b1, 1'b0, 1'b1, 16'h3103);
        check_bank("req_at_apply", 1'b0, 1'b1);
        pix(8'h40, 8'h40, 1'b0, 1'b1, 1'b0, 16'h4104);
        idle(1);
        pix(8'h50, 8'h50, 1'b1, 1'b1, 1'b0, 16'hAF50);
        check_bank("rearmed_apply", 1'b1, 1'b0);
        idle(2);

        // Write in the apply cycle lands in the bank becoming active (bank 0).
        pulse_req();
        bus.tbl_wr_en   = 1'b1;
        bus.tbl_wr_ch   = 1'b0;
        bus.tbl_wr_addr = 8'h40;
        bus.tbl_wr_data = 8'h99;
        pix(8'h50, 8'h50, 1'b1, 1'b0, 1'b0, 16'h5105);
        bus.tbl_wr_en   = 1'b0;
        pix(8'h40, 8'h40, 1'b0, 1'b1, 1'b0, 16'h4199);
        check_bank("wr_at_apply", 1'b0, 1'b0);
        idle(2);

        // Bank 1 entry 0x40 untouched; then reset mid-frame with a swap armed.
        pulse_req();
        pix(8'h40, 8'h12, 1'b1, 1'b0, 1'b0, 16'hED40);
        check_bank("pre_reset", 1'b1, 1'b0);
        pulse_req();
        pix(8'h77, 8'h00, 1'b0, 1'b0, 1'b0, 16'hFF77);
        bus.raw_data_valid = 1'b1;
        bus.raw_data       = 16'h0102;
        reset = 1'b1;
        #1;
        check("midrst_data", 32'(bus.gamma_data), 32'd0);
        check("midrst_strobes", 32'({bus.gamma_data_valid, bus.gamma_data_sop, bus.gamma_data_eop}), 32'd0);
        check_bank("midrst", 1'b0, 1'b0);
        bus.raw_data_valid = 1'b0;
        step();
        reset = 1'b0;
        idle(3);
        pix(8'h12, 8'h40, 1'b1, 1'b0, 1'b0, 16'h4121);
        check_bank("post_reset", 1'b0, 1'b0);
        pix(8'h34, 8'h99, 1'b0, 1'b1, 1'b0, 16'h9A43);
        idle(2);

`ifdef GAMMA_LUT_BYPASS_EN
        bus.bypass = 1'b1;
        pix(8'hA5, 8'hA5, 1'b1, 1'b1, 1'b0, 16'hA5A5);
        bus.bypass = 1'b0;
`endif
        pix(8'hA5, 8'hA5, 1'b1, 1'b1, 1'b0, 16'hA65A);
        idle(5);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gamma_lut_mc.md
# gamma_lut_mc

Multi-channel, parametrised gamma-correction stage with on-chip, runtime-loadable lookup tables. Each table is double-buffered, and a table swap takes effect only at a frame boundary. The block sits in the video pipeline between the raw pixel stream and the downstream tone-mapping/HDR merge stages. It replaces external per-channel LUT address/data wiring with internal banked RAM and a fixed 2-cycle pipeline.

## Interface
- `CH`, default 2: number of pixel channels processed in parallel.
- `DW`, default 8: input sample width. LUT depth is 2^DW.
- `OW`, default 8: output sample width (LUT word width).

- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `raw_data`, in, CH*DW: input samples; channel i occupies bits [i*DW +: DW].
- `raw_data_valid`, in, 1: sample qualifier.
- `raw_data_sop`, in, 1: first pixel of frame; meaningful only when valid.
- `raw_data_eop`, in, 1: last pixel of frame; meaningful only when valid.
- `tbl_wr_en`, in, 1: LUT write strobe.
- `tbl_wr_ch`, in, $clog2(CH) (min 1): target channel table.
- `tbl_wr_addr`, in, DW: table entry index.
- `tbl_wr_data`, in, OW: table entry value.
- `tbl_swap_req`, in, 1: single-cycle pulse requesting a shadow/active swap at the next frame start.
- `tbl_swap_pending`, out, 1: a swap is armed but not yet applied.
- `tbl_active_bank`, out, 1: bank currently used for lookup.
- `gamma_data`, out, CH*OW: corrected samples, packed the same way as `raw_data`.
- `gamma_data_valid`, `gamma_data_sop`, `gamma_data_eop`, out, 1 each: strobes aligned to `gamma_data`.
- `bypass`, in, 1: present only with `GAMMA_LUT_BYPASS_EN`.

## Operation
- Per channel there are two banks of 2^DW x OW RAM (bank 0, bank 1): 2*CH tables in total.
- **Writes** always target the shadow bank, i.e. bank `~tbl_active_bank` as sampled in the write cycle.
- **Swap arming:** `tbl_swap_req` sets `tbl_swap_pending`. A request while already pending is a no-op.
- **Swap apply:** a swap is applied on the first cycle where `raw_data_valid & raw_data_sop & tbl_swap_pending`. In that cycle `tbl_active_bank` toggles and pending clears.
  - The SOP pixel itself is looked up in the new bank.
  - A swap is never applied mid-frame.
- **Simultaneous events:**
  - `tbl_swap_req` in the same cycle as an applying SOP: the current pending is consumed and pending stays set (re-armed for the next frame).
  - `tbl_swap_req` with no pending, coinciding with SOP: it arms only and applies at the following SOP.
  - A write in the apply cycle goes to the pre-swap shadow bank, which is the bank becoming active. This is a legal but software-prohibited case, and the bench checks the deterministic result.
- **Lookup:** stage 1 registers the address and bank select. Stage 2 registers the RAM read data into `gamma_data`. Strobes are delayed 2 cycles through a matching shift register.
- When valid is low, RAM reads still occur. `gamma_data` holds its last value; only the strobes carry 0.
- **Reset:**
  - Clears the pipeline registers, strobes, `gamma_data`, `tbl_active_bank` (0) and `tbl_swap_pending` (0).
  - RAM contents are not cleared. Software reloads the tables after reset if required.
  - Reset mid-frame drops in-flight samples; no partial strobes are emitted after deassertion.

## Timing
- **Latency:** input at cycle N produces output at cycle N+2, with full throughput (one sample per channel per cycle).
- **Write-to-use:** an entry written at cycle W is visible to lookups once its bank is active, i.e. at the earliest from the SOP following a swap armed after W.
- **Output reset values:**
  - `gamma_data` = 0.
  - `gamma_data_valid`/`gamma_data_sop`/`gamma_data_eop` = 0.
  - `tbl_active_bank` = 0.
  - `tbl_swap_pending` = 0.
- `tbl_swap_pending` and `tbl_active_bank` are registered and update one cycle after the triggering edge condition.

## Configuration
- `GAMMA_LUT_BYPASS_EN` defined:
  - Adds a `bypass` input. It is sampled with the data in stage 1.
  - When set, the output for channel i is `raw_data` channel i, zero-extended if OW>DW or taking the MSBs if OW<DW.
  - Latency stays 2 cycles, and table writes and swaps remain operational.
- `GAMMA_LUT_BYPASS_EN` undefined: the `bypass` port and its mux are absent; output is always the LUT value.

## Test plan
- **Identity load:** CH=2, DW=OW=8. Load bank 1 with addr->addr for ch0 and addr->255-addr for ch1, pulse swap, then send a frame with SOP. Response: in=0x10/0x10 gives out=0x10/0xEF two cycles later, and `tbl_active_bank`=1.
- **Frame-boundary swap:** swap_req mid-frame. Response: remaining pixels use the old bank, the pixel at the next SOP uses the new bank, and pending clears the cycle after that SOP.
- **Strobe alignment:** a 4-pixel frame with valid gaps. Response: valid/sop/eop appear exactly 2 cycles later, and `gamma_data` holds its value during gaps.
- **Double request:** two swap_req pulses before an SOP. Response: exactly one toggle; a req coincident with the applying SOP leaves pending=1 and toggles again at the next SOP.
- **Reset mid-frame:** assert reset during a frame. Response: all outputs 0 next cycle, bank=0 and pending=0; after release, the RAM still holds its prior contents (verified via bank 0 lookup).
- **With `GAMMA_LUT_BYPASS_EN`:** bypass=1 and in=0xA5. Response: out=0xA5 at N+2 regardless of the LUT contents.
